// File: rtl/y86_pkg.sv
// Shared Y86 definitions: word geometry, instruction codes and the
// instruction-length helper used by both fetch and the prefetch buffer.
package y86_pkg;

    localparam int WORD_W     = 64;
    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = WORD_W / BYTE_W;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    // Byte length of an instruction given its icode; unknown codes report 1
    // so fetch can still advance past them while flagging an illegal op.
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        logic [3:0] len;
        case (icode)
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: len = 4'd2;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     len = 4'd10;
            I_JXX, I_CALL:                    len = 4'd9;
            default:                          len = 4'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/pf_byte_queue.sv
// Circular byte store for the prefetch buffer: each entry is a byte plus its
// fault bit. Appends up to one word at the tail, exposes 8 bytes at the head.
module pf_byte_queue
    import y86_pkg::*;
#(
    parameter int DEPTH_W = 4,
    localparam int QBYTES = DEPTH_W * WORD_BYTES,
    localparam int CNT_W  = $clog2(QBYTES + 1),
    localparam int PTR_W  = $clog2(QBYTES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [2:0]       wr_skip,
    input  logic [63:0]      wr_data,
    input  logic             wr_err,
    input  logic             pop_en,
    input  logic [3:0]       pop_len,
    output logic [63:0]      win_data,
    output logic [7:0]       win_err,
    output logic [CNT_W-1:0] count
);

    logic [8:0]       mem [QBYTES];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [3:0]       wr_amt;

    // Pointer advance modulo the queue size; works for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr,
                                                  input logic [3:0] off);
        logic [PTR_W:0] s;
        s = {1'b0, ptr} + {{(PTR_W-3){1'b0}}, off};
        if (s >= (PTR_W+1)'(QBYTES))
            s = s - (PTR_W+1)'(QBYTES);
        return s[PTR_W-1:0];
    endfunction

    assign wr_amt = 4'd8 - {1'b0, wr_skip};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < QBYTES; i++)
                mem[i] <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                for (int k = 0; k < 8; k++) begin
                    if (k >= int'(wr_skip))
                        mem[wrap_add(tail, 4'(k) - {1'b0, wr_skip})] <= {wr_err, wr_data[8*k +: 8]};
                end
                tail <= wrap_add(tail, wr_amt);
            end
            if (pop_en)
                head <= wrap_add(head, pop_len);
            count <= count + CNT_W'(wr_en ? wr_amt : 4'd0) - CNT_W'(pop_en ? pop_len : 4'd0);
        end
    end

    always_comb begin
        win_data = '0;
        win_err  = '0;
        for (int k = 0; k < 8; k++) begin
            win_data[8*k +: 8] = mem[wrap_add(head, 4'(k))][7:0];
            win_err[k]         = mem[wrap_add(head, 4'(k))][8];
        end
    end

endmodule

// File: rtl/y86_prefetch_buffer.sv
// Instruction prefetch buffer: issues aligned word reads ahead of the fetch PC
// and presents an unaligned 8-byte window to the fetch stage.
module y86_prefetch_buffer
    import y86_pkg::*;
#(
    parameter int          DEPTH_W  = 4,
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          MAX_OUT  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        consume,
    input  logic [3:0]  consume_len,
    output logic        win_valid,
    output logic [63:0] win_pc,
    output logic [63:0] win_data,
    output logic        win_error,
    output logic        mem_req_valid,
    output logic [63:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_data,
    input  logic        mem_rsp_error
);

    localparam int QBYTES = DEPTH_W * WORD_BYTES;
    localparam int CNT_W  = $clog2(QBYTES + 1);
    localparam int OUT_W  = $clog2(MAX_OUT + 1);

    logic             started;
    logic [63:0]      req_addr;
    logic [2:0]       skip;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] drop;
    logic [OUT_W-1:0] out_next;
    logic [CNT_W-1:0] q_count;
    logic [7:0]       win_err;
    logic [31:0]      credit_used;
    logic             req_hs;
    logic             rsp_keep;
    logic             rsp_discard;
    logic             cons_ok;

    // Every in-flight read reserves a full word of space so no response can overflow.
    assign credit_used   = 32'(q_count) + (32'(outstanding) << 3) + 32'd8;
    assign mem_req_valid = started && (outstanding < OUT_W'(MAX_OUT))
                           && (credit_used <= 32'(QBYTES));
    assign mem_req_addr  = req_addr;

    assign req_hs      = mem_req_valid & mem_req_ready;
    assign rsp_keep    = mem_rsp_valid & ~redirect & (drop == '0);
    assign rsp_discard = mem_rsp_valid & ~redirect & (drop != '0);
    assign cons_ok     = consume & win_valid & ~redirect
                         & (consume_len != 4'd0) & (consume_len <= 4'd8);
    assign out_next    = outstanding + OUT_W'(req_hs) - OUT_W'(mem_rsp_valid);

    assign win_valid = (q_count >= CNT_W'(8));
    assign win_error = |win_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started     <= 1'b0;
            win_pc      <= RESET_PC;
            req_addr    <= {RESET_PC[63:3], 3'b000};
            skip        <= RESET_PC[2:0];
            outstanding <= '0;
            drop        <= '0;
        end else begin
            started     <= 1'b1;
            outstanding <= out_next;
            if (redirect) begin
                // Everything still in flight after this edge belongs to the old stream.
                win_pc   <= redirect_pc;
                req_addr <= {redirect_pc[63:3], 3'b000};
                skip     <= redirect_pc[2:0];
                drop     <= out_next;
            end else begin
                if (req_hs)
                    req_addr <= req_addr + 64'd8;
                if (cons_ok)
                    win_pc <= win_pc + 64'(consume_len);
                if (rsp_discard)
                    drop <= drop - OUT_W'(1);
                if (rsp_keep)
                    skip <= 3'd0;
            end
        end
    end

    pf_byte_queue #(.DEPTH_W(DEPTH_W)) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect),
        .wr_en    (rsp_keep),
        .wr_skip  (skip),
        .wr_data  (mem_rsp_data),
        .wr_err   (mem_rsp_error),
        .pop_en   (cons_ok),
        .pop_len  (consume_len),
        .win_data (win_data),
        .win_err  (win_err),
        .count    (q_count)
    );

endmodule

// File: tb/tb_y86_prefetch_buffer.sv
// Directed bench for y86_prefetch_buffer with an in-order memory model whose
// byte at address a is a[7:0].
module tb_y86_prefetch_buffer;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        consume;
    logic [3:0]  consume_len;
    logic        win_valid;
    logic [63:0] win_pc;
    logic [63:0] win_data;
    logic        win_error;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic        mem_rsp_error;

    logic        rsp_hold;
    logic        err_en;
    logic [63:0] err_addr;
    logic [63:0] addr_q[$];
    logic [63:0] hs_log[$];
    int          n_chk;
    int          n_pass;
    int          mark;

    y86_prefetch_buffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .consume       (consume),
        .consume_len   (consume_len),
        .win_valid     (win_valid),
        .win_pc        (win_pc),
        .win_data      (win_data),
        .win_error     (win_error),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_error (mem_rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input logic [63:0] pc);
        logic [63:0] r;
        logic [63:0] a;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            a = pc + 64'(k);
            r[8*k +: 8] = a[7:0];
        end
        return r;
    endfunction

    // Memory model: accepted addresses queue up, answered one per cycle in order.
    always @(posedge clk) begin
        if (!rst_n) begin
            addr_q.delete();
        end else begin
            if (mem_req_valid && mem_req_ready) begin
                addr_q.push_back(mem_req_addr);
                hs_log.push_back(mem_req_addr);
            end
            if (mem_rsp_valid && addr_q.size() > 0)
                void'(addr_q.pop_front());
        end
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
            mem_rsp_error = 1'b0;
        end else if (!rsp_hold && addr_q.size() > 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = pat(addr_q[0]);
            mem_rsp_error = err_en && (addr_q[0] == err_addr);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_error = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !win_valid; i++)
            tick();
        chk(tag, 64'(win_valid), 64'd1);
    endtask

    task automatic do_consume(input logic [3:0] len);
        consume     = 1'b1;
        consume_len = len;
        tick();
        consume     = 1'b0;
        consume_len = 4'd0;
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        consume     = 1'b0;
        consume_len = 4'd0;
        mem_req_ready = 1'b1;
        rsp_hold    = 1'b0;
        err_en      = 1'b0;
        err_addr    = 64'h8;

        tick();
        tick();
        chk("rst_win_pc",    win_pc, 64'h0);
        chk("rst_win_valid", 64'(win_valid), 64'd0);
        chk("rst_win_data",  win_data, 64'h0);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_win_error", 64'(win_error), 64'd0);

        // Cold start: window valid after the third edge.
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        mark  = hs_log.size();
        tick();
        tick();
        chk("cold_not_yet_valid", 64'(win_valid), 64'd0);
        tick();
        chk("cold_valid_c3", 64'(win_valid), 64'd1);
        chk("cold_data", win_data, 64'h0706050403020100);

        // Hold consume low until the credit limit stops requests at 32 bytes.
        repeat (5) tick();
        chk("full_req_count", 64'(hs_log.size() - mark), 64'd4);
        chk("full_req_valid", 64'(mem_req_valid), 64'd0);
        chk("full_req_addr", mem_req_addr, 64'h20);

        do_consume(4'd6);
        chk("c6_pc", win_pc, 64'h6);
        chk("c6_data", win_data, 64'h0D0C0B0A09080706);
        do_consume(4'd2);
        chk("c2_pc", win_pc, 64'h8);
        chk("c2_data", win_data, 64'h0F0E0D0C0B0A0908);
        chk("c2_req_valid", 64'(mem_req_valid), 64'd1);
        chk("c2_req_addr", mem_req_addr, 64'h20);

        do_consume(4'd0);
        chk("len0_ignored", win_pc, 64'h8);
        do_consume(4'd9);
        chk("len9_ignored", win_pc, 64'h8);

        // Draining the full queue shows no byte was lost while it was full.
        for (int i = 0; i < 4; i++) begin
            do_consume(4'd8);
            chk("drain_pc", win_pc, 64'h10 + 64'(8 * i));
            chk("drain_data", win_data, pat(64'h10 + 64'(8 * i)));
        end

        // Faulted word at 0x08 only shows once the window reaches it.
        err_en      = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'h0;
        tick();
        redirect    = 1'b0;
        wait_valid("err_wait");
        chk("err_pc0", win_pc, 64'h0);
        chk("err_at_pc0", 64'(win_error), 64'd0);
        chk("err_data0", win_data, 64'h0706050403020100);
        tick();
        tick();
        tick();
        do_consume(4'd1);
        chk("err_pc1", win_pc, 64'h1);
        chk("err_at_pc1", 64'(win_error), 64'd1);
        do_consume(4'd8);
        chk("err_at_pc9", 64'(win_error), 64'd1);
        do_consume(4'd7);
        chk("err_pc16", win_pc, 64'h10);
        chk("err_at_pc16", 64'(win_error), 64'd0);
        err_en = 1'b0;

        // Redirect, consume and a response all land on the same edge.
        for (int i = 0; i < 20 && !(mem_rsp_valid && win_valid); i++)
            tick();
        chk("same_cyc_pre", 64'(mem_rsp_valid && win_valid), 64'd1);
        redirect    = 1'b1;
        redirect_pc = 64'h45;
        consume     = 1'b1;
        consume_len = 4'd3;
        tick();
        redirect    = 1'b0;
        consume     = 1'b0;
        consume_len = 4'd0;
        chk("same_cyc_pc", win_pc, 64'h45);
        chk("same_cyc_invalid", 64'(win_valid), 64'd0);
        wait_valid("same_cyc_wait");
        chk("same_cyc_pc2", win_pc, 64'h45);
        chk("same_cyc_data", win_data, 64'h4C4B4A4948474645);

        // Asynchronous reset in the middle of a burst.
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", win_pc, 64'h0);
        chk("async_rst_valid", 64'(win_valid), 64'd0);
        chk("async_rst_data", win_data, 64'h0);
        chk("async_rst_req", 64'(mem_req_valid), 64'd0);
        chk("async_rst_err", 64'(win_error), 64'd0);
        tick();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        wait_valid("post_rst_wait");
        chk("post_rst_pc", win_pc, 64'h0);
        chk("post_rst_data", win_data, 64'h0706050403020100);

        // Redirect with two reads in flight: both stale words must be dropped.
        rsp_hold = 1'b1;
        apply_reset();
        mark = hs_log.size();
        tick();
        tick();
        tick();
        chk("stall_reqs", 64'(hs_log.size() - mark), 64'd2);
        chk("stall_req_valid", 64'(mem_req_valid), 64'd0);
        redirect    = 1'b1;
        redirect_pc = 64'h13;
        tick();
        redirect    = 1'b0;
        chk("rd13_pc", win_pc, 64'h13);
        chk("rd13_invalid", 64'(win_valid), 64'd0);
        chk("rd13_req_blocked", 64'(mem_req_valid), 64'd0);
        mark     = hs_log.size();
        rsp_hold = 1'b0;
        wait_valid("rd13_wait");
        chk("rd13_pc2", win_pc, 64'h13);
        chk("rd13_data", win_data, 64'h1A19181716151413);
        chk("rd13_req0", hs_log[mark], 64'h10);
        chk("rd13_req1", hs_log[mark + 1], 64'h18);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
